vga_marker_gen: RTL and testbench

Generates the 640x480 VGA pixel stream and timing for the capture path and inserts full-frame colour markers that the downstream detection logic uses to open and close a detection window. A white marker (all channels at WHITE_LVL) opens the window and a black marker (all channels at BLACK_LVL) closes it. Between markers it passes the upstream pixel source through, clamped so that ordinary content can never be mistaken for a marker. It sits between the pixel source and the VGA output/detector pins.

---
 rtl/vga_marker_gen.sv | 188 ++++++++++++++++++
 tb/tb_vga_marker_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_marker_gen.sv
// VGA 640x480 timing generator with full-frame white/black marker insertion.
// Idle content is clamped so it can never satisfy the detector's marker thresholds.
module vga_marker_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned MARK_FRAMES = 2,
    parameter logic [7:0]  WHITE_LVL   = 8'hFF,
    parameter logic [7:0]  BLACK_LVL   = 8'h00,
    parameter logic [7:0]  CLAMP_LO    = 8'h20,
    parameter logic [7:0]  CLAMP_HI    = 8'hAF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mark_start_req,
    input  logic       mark_finish_req,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       busy,
    output logic       mark_done
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FW      = (MARK_FRAMES < 2) ? 1 : $clog2(MARK_FRAMES + 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [FW-1:0] FCNT_LOAD = FW'(MARK_FRAMES);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PEND_W,
        MARK_W,
        PEND_B,
        MARK_B
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic          done_q, done_d;
    logic          h_wrap, v_wrap, last_px, active;

    function automatic logic [7:0] clamp8(input logic [7:0] x);
        if (x < CLAMP_LO) return CLAMP_LO;
        if (x > CLAMP_HI) return CLAMP_HI;
        return x;
    endfunction

    assign h_wrap  = (h_cnt_q == H_LAST);
    assign v_wrap  = (v_cnt_q == V_LAST);
    assign last_px = h_wrap && v_wrap;
    assign active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Start has priority; a simultaneous finish request is dropped.
                if (mark_start_req) begin
                    state_d = PEND_W;
                end else if (mark_finish_req) begin
                    state_d = PEND_B;
                end
            end
            PEND_W, PEND_B: begin
                if (last_px) begin
                    state_d = (state_q == PEND_W) ? MARK_W : MARK_B;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            MARK_W, MARK_B: begin
                if (last_px) begin
                    fcnt_d = fcnt_q - FCNT_ONE;
                    if (fcnt_q == FCNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active) begin
            case (state_q)
                MARK_W: begin
                    r_d = WHITE_LVL;
                    g_d = WHITE_LVL;
                    b_d = WHITE_LVL;
                end
                MARK_B: begin
                    r_d = BLACK_LVL;
                    g_d = BLACK_LVL;
                    b_d = BLACK_LVL;
                end
                default: begin
                    r_d = clamp8(pix_r);
                    g_d = clamp8(pix_g);
                    b_d = clamp8(pix_b);
                end
            endcase
        end
        hs_d      = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_d      = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        blank_n_d = active;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            fcnt_q    <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            done_q    <= done_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign busy        = (state_q != IDLE);
    assign mark_done   = done_q;

endmodule

// File: tb/tb_vga_marker_gen.sv
// Bench for vga_marker_gen on a shrunken raster; expectations come from a
// frame-arithmetic model of marker timing plus a constant clamp table.
module tb_vga_marker_gen;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 6, VF = 1, VSY = 2, VB = 2;
    localparam int MF = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       mark_start_req, mark_finish_req;
    logic [7:0] pix_r, pix_g, pix_b;
    logic [9:0] h_cnt, v_cnt;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, busy, mark_done;

    vga_marker_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .MARK_FRAMES(MF)
    ) dut (
        .clk(clk), .rst(rst),
        .mark_start_req(mark_start_req), .mark_finish_req(mark_finish_req),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .busy(busy), .mark_done(mark_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: cycle index since reset release plus the one outstanding marker.
    int         n;
    bit         mv;
    int         m_req, m_start, m_end;
    bit         m_white;
    logic [7:0] pr, pg, pb;

    int done_seen, white_px, black_px;
    int first_hs, first_vs, second_vs;
    logic vs_prev;

    typedef struct {
        logic [7:0] r, g, b;
        logic [7:0] er, eg, eb;
    } clamp_vec_t;
    clamp_vec_t cv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
            if (errors > 100) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    function automatic int mh(input int t); return t % HT; endfunction
    function automatic int mvc(input int t); return (t / HT) % VT; endfunction
    function automatic bit m_busy(input int t); return mv && t > m_req && t < m_end; endfunction
    function automatic bit m_mark(input int t); return mv && t >= m_start && t < m_end; endfunction
    function automatic bit m_done(input int t); return mv && t == m_end; endfunction
    function automatic logic [7:0] clampm(input logic [7:0] x);
        return (x < 8'h20) ? 8'h20 : ((x > 8'hAF) ? 8'hAF : x);
    endfunction

    task automatic check_cycle();
        logic [7:0] er, eg, eb;
        logic ehs, evs, ebl;
        int t;
        if (n == 0) begin
            er = 0; eg = 0; eb = 0; ehs = 1; evs = 1; ebl = 0;
        end else begin
            t   = n - 1;
            ebl = (mh(t) < HA) && (mvc(t) < VA);
            ehs = !(mh(t) >= HA + HF && mh(t) < HA + HF + HSY);
            evs = !(mvc(t) >= VA + VF && mvc(t) < VA + VF + VSY);
            if (!ebl) begin
                er = 0; eg = 0; eb = 0;
            end else if (m_mark(t)) begin
                er = m_white ? 8'hFF : 8'h00; eg = er; eb = er;
            end else begin
                er = clampm(pr); eg = clampm(pg); eb = clampm(pb);
            end
        end
        chk("h_cnt", h_cnt, mh(n));
        chk("v_cnt", v_cnt, mvc(n));
        chk("vga_r", vga_r, er);
        chk("vga_g", vga_g, eg);
        chk("vga_b", vga_b, eb);
        chk("vga_hs", vga_hs, ehs);
        chk("vga_vs", vga_vs, evs);
        chk("vga_blank_n", vga_blank_n, ebl);
        chk("busy", busy, m_busy(n));
        chk("mark_done", mark_done, m_done(n));
        if (mark_done === 1'b1) done_seen++;
        if (vga_blank_n === 1'b1 && vga_r == 8'hFF && vga_g == 8'hFF && vga_b == 8'hFF) white_px++;
        if (vga_blank_n === 1'b1 && vga_r == 8'h00 && vga_g == 8'h00 && vga_b == 8'h00) black_px++;
        if (vga_hs === 1'b0 && first_hs < 0) first_hs = n;
        if (vga_vs === 1'b0 && vs_prev === 1'b1) begin
            if (first_vs < 0) first_vs = n;
            else if (second_vs < 0) second_vs = n;
        end
        vs_prev = vga_vs;
    endtask

    task automatic step(input bit sr, input bit fr, input logic [7:0] r, g, b);
        check_cycle();
        mark_start_req  = sr;
        mark_finish_req = fr;
        pix_r = r; pix_g = g; pix_b = b;
        if ((sr || fr) && !m_busy(n)) begin
            mv      = 1;
            m_req   = n;
            m_start = ((n + 1) / FR + 1) * FR;
            m_end   = m_start + MF * FR;
            m_white = sr;
        end
        pr = r; pg = g; pb = b;
        @(negedge clk);
        n++;
    endtask

    task automatic rstep(input bit sr, input bit fr);
        step(sr, fr, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) rstep(0, 0);
    endtask

    task automatic run_to(input int h, input int v);
        int k = 0;
        while (!(mh(n) == h && mvc(n) == v) && k < 2 * FR) begin
            rstep(0, 0);
            k++;
        end
    endtask

    task automatic reset_model();
        n = 0; mv = 0; vs_prev = 1'b1;
        first_hs = -1; first_vs = -1; second_vs = -1;
    endtask

    initial begin
        int d0, w0, b0;
        cv[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hAF, 8'hAF, 8'hAF};
        cv[1] = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20};
        cv[2] = '{8'h40, 8'h80, 8'hC0, 8'h40, 8'h80, 8'hAF};
        cv[3] = '{8'h1F, 8'h20, 8'h21, 8'h20, 8'h20, 8'h21};
        cv[4] = '{8'hAE, 8'hAF, 8'hB0, 8'hAE, 8'hAF, 8'hAF};
        cv[5] = '{8'h10, 8'hF0, 8'h90, 8'h20, 8'hAF, 8'h90};
        cv[6] = '{8'h7F, 8'h01, 8'hFE, 8'h7F, 8'h20, 8'hAF};
        cv[7] = '{8'h20, 8'hAF, 8'h55, 8'h20, 8'hAF, 8'h55};

        rst = 1'b1;
        mark_start_req = 0; mark_finish_req = 0;
        pix_r = 0; pix_g = 0; pix_b = 0; pr = 0; pg = 0; pb = 0;
        done_seen = 0; white_px = 0; black_px = 0;
        m_req = 0; m_start = 0; m_end = 0; m_white = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        reset_model();

        // Reset release and raster timing
        run(2 * FR + 10);
        chk("first_hs_low_cycle", first_hs, HA + HF + 1);
        chk("first_vs_low_cycle", first_vs, (VA + VF) * HT + 1);
        chk("frame_period", second_vs - first_vs, FR);

        // Idle clamp table
        for (int i = 0; i < 8; i++) begin
            int k = 0;
            while (!(mh(n) < HA && mvc(n) < VA) && k < FR) begin
                rstep(0, 0);
                k++;
            end
            step(0, 0, cv[i].r, cv[i].g, cv[i].b);
            chk($sformatf("clamp_r[%0d]", i), vga_r, cv[i].er);
            chk($sformatf("clamp_g[%0d]", i), vga_g, cv[i].eg);
            chk($sformatf("clamp_b[%0d]", i), vga_b, cv[i].eb);
        end

        // White marker requested at (5,3)
        run_to(5, 3);
        d0 = done_seen; w0 = white_px;
        rstep(1, 0);
        chk("start_busy_rises", busy, 1);
        run(3 * FR);
        chk("start_done_pulses", done_seen - d0, 1);
        chk("start_white_pixels", white_px - w0, MF * HA * VA);

        // Black marker requested at (5,3)
        run_to(5, 3);
        d0 = done_seen; b0 = black_px;
        rstep(0, 1);
        run(3 * FR);
        chk("finish_done_pulses", done_seen - d0, 1);
        chk("finish_black_pixels", black_px - b0, MF * HA * VA);

        // Simultaneous requests, then a finish request during MARK_W
        d0 = done_seen; w0 = white_px; b0 = black_px;
        rstep(1, 1);
        while (n < m_start + 50) rstep(0, 0);
        rstep(0, 1);
        run(3 * FR);
        chk("simul_done_pulses", done_seen - d0, 1);
        chk("simul_white_pixels", white_px - w0, MF * HA * VA);
        chk("simul_black_pixels", black_px - b0, 0);

        // Asynchronous reset in the middle of MARK_W
        rstep(1, 0);
        while (n < m_start + FR + 40) rstep(0, 0);
        d0 = done_seen;
        #2 rst = 1'b1;
        mark_start_req = 0; mark_finish_req = 0;
        #1;
        chk("rst_h_cnt", h_cnt, 0);
        chk("rst_v_cnt", v_cnt, 0);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_syncs", {vga_hs, vga_vs, vga_blank_n}, 3'b110);
        chk("rst_busy_done", {busy, mark_done}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        w0 = white_px;
        run(3 * FR);
        chk("rst_no_done", done_seen - d0, 0);
        chk("rst_no_white", white_px - w0, 0);

        // Random requests across many frames
        for (int i = 0; i < 10 * FR; i++)
            rstep($urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
